// File: rtl/roll_sequencer.sv
// Dice-roll sequencer: button press -> timed LED shuffle with en strobes -> lockout.
// Define ROLL_DEBOUNCE_EN to insert a counter-based debounce filter on the button.
module roll_sequencer #(
  parameter int TICK_DIV        = 10_000_000,
  parameter int ROLL_TICKS      = 15,
  parameter int HOLD_TICKS      = 5,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  output logic       en,
  output logic       tick,
  output logic [9:0] LED,
  output logic       busy,
  output logic [7:0] roll_count
);

  localparam int DIV_W    = $clog2(TICK_DIV);
  localparam int STEP_MAX = (ROLL_TICKS > HOLD_TICKS) ? ROLL_TICKS : HOLD_TICKS;
  localparam int STEP_W   = $clog2(STEP_MAX + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] ROLL_LAST = STEP_W'(ROLL_TICKS - 1);
  localparam logic [STEP_W-1:0] HOLD_LAST = STEP_W'(HOLD_TICKS - 1);

  if (TICK_DIV < 2 || ROLL_TICKS < 1 || HOLD_TICKS < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("roll_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ROLL, HOLD} state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]        vld_pipe_q, vld_pipe_d;
  logic              settled_q, settled_d;
  logic              prev_q, prev_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [9:0]        led_q, led_d;
  logic              en_q, en_d, tick_q, tick_d, busy_q, busy_d;
  logic [7:0]        rc_q, rc_d;
  logic              lvl_sync, lvl, press, tick_evt;

  // Input path. vld_pipe marks when the synchronizer holds real post-reset
  // samples; until the filtered level agrees with them the edge detector
  // stays parked at "pressed", so a button held through reset cannot fire.
  assign lvl_sync = ~sync2_q;

`ifdef ROLL_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  logic            filt_q, filt_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    if (lvl_sync != filt_q) begin
      if (db_cnt_q == DB_LAST) filt_d = lvl_sync;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign lvl = filt_q;
  assign settled_d = settled_q | (vld_pipe_q[1] & (lvl_sync == filt_q));
`else
  assign lvl = lvl_sync;
  assign settled_d = settled_q | vld_pipe_q[1];
`endif

  always_comb begin
    sync1_d    = button;
    sync2_d    = sync1_q;
    vld_pipe_d = {vld_pipe_q[0], 1'b1};
    prev_d     = settled_q ? lvl : 1'b1;
  end

  assign press    = settled_q & lvl & ~prev_q;
  assign tick_evt = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    led_d   = led_q;
    rc_d    = rc_q;
    en_d    = 1'b0;
    tick_d  = tick_evt;
    div_d   = tick_evt ? '0 : div_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        led_d = '0;
        if (press) begin
          state_d = ROLL;
          step_d  = '0;
          led_d   = 10'h001;
          div_d   = '0;
        end
      end
      ROLL: begin
        if (tick_evt) begin
          en_d  = 1'b1;
          led_d = {led_q[8:0], led_q[9]};
          if (step_q == ROLL_LAST) begin
            state_d = HOLD;
            step_d  = '0;
            led_d   = 10'h3FF;
            rc_d    = rc_q + 8'd1;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      HOLD: begin
        led_d = 10'h3FF;
        if (tick_evt) begin
          if (step_q == HOLD_LAST) begin
            state_d = IDLE;
            step_d  = '0;
            led_d   = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      vld_pipe_q <= '0;
      settled_q  <= 1'b0;
      prev_q     <= 1'b1;
      div_q      <= '0;
      step_q     <= '0;
      led_q      <= '0;
      en_q       <= 1'b0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
      rc_q       <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      vld_pipe_q <= vld_pipe_d;
      settled_q  <= settled_d;
      prev_q     <= prev_d;
      div_q      <= div_d;
      step_q     <= step_d;
      led_q      <= led_d;
      en_q       <= en_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
      rc_q       <= rc_d;
    end
  end

  assign en         = en_q;
  assign tick       = tick_q;
  assign LED        = led_q;
  assign busy       = busy_q;
  assign roll_count = rc_q;

endmodule
